// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, default latencies and decode helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle mult/div beside the E-stage ALU; owns HI/LO and asks decode to stall.
// The result is computed at accept time; the counter only models the architectural latency.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        exc_flush,
    input  logic        d_uses_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pend;
    logic          pend_wr;

    logic          accept;
    logic [63:0]   result;
    logic          result_wr;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [31:0]   divisor;

    assign accept   = start & ~exc_flush;
    assign md_stall = d_uses_md & (busy | (start & is_muldiv(op)));

    // Divisor forced non-zero so the divider never produces X; the write is dropped instead.
    assign divisor = (b == 32'd0) ? 32'd1 : b;

    always_comb begin
        result    = 64'd0;
        result_wr = 1'b1;
        quo       = 32'd0;
        rem       = 32'd0;
        case (op)
            MD_MULT: begin
                result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            end
            MD_MULTU: begin
                result = {32'd0, a} * {32'd0, b};
            end
            MD_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rem = 32'd0;
                end else begin
                    quo = $signed(a) / $signed(divisor);
                    rem = $signed(a) % $signed(divisor);
                end
                result    = {rem, quo};
                result_wr = (b != 32'd0);
            end
            MD_DIVU: begin
                quo       = a / divisor;
                rem       = a % divisor;
                result    = {rem, quo};
                result_wr = (b != 32'd0);
            end
            default: begin
                result_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_muldiv(op)) begin
                            pend    <= result;
                            pend_wr <= result_wr;
                            cnt     <= is_div(op) ? DIV_LD : MULT_LD;
                            busy    <= 1'b1;
                            state   <= BUSY;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                BUSY: begin
                    // start and exc_flush are ignored here: the running op is older than anything in E.
                    if (cnt == '0) begin
                        if (pend_wr) begin
                            hi <= pend[63:32];
                            lo <= pend[31:0];
                        end
                        pend_wr <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exc_flush;
    logic        d_uses_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .exc_flush(exc_flush), .d_uses_md(d_uses_md),
        .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, count busy cycles, then pop and compare HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int n,
                          input int flush_at, input logic dum);
        int cyc;
        logic [63:0] e;
        sb_q.push_back(exp);
        op = o; a = av; b = bv; start = 1'b1; exc_flush = 1'b0; d_uses_md = dum;
        #1;
        chk({tag, "_stall_issue"}, {63'd0, md_stall}, {63'd0, dum});
        step();
        start = 1'b0; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            exc_flush = (cyc == flush_at);
            if (md_stall !== dum) chk({tag, "_stall_busy"}, {63'd0, md_stall}, {63'd0, dum});
            cyc++;
            step();
        end
        exc_flush = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        chk({tag, "_stall_idle"}, {63'd0, md_stall}, 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, e);
        end
        d_uses_md = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_MULT; a = 32'd0; b = 32'd0;
        exc_flush = 1'b0; d_uses_md = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, md_stall}, 64'd0);

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, -1, 1'b1);
        run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 5, -1, 1'b0);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, -1, 1'b1);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 10, -1, 1'b0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, -1, 1'b1);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, -1, 1'b0);

        // MTHI writes in one edge and never raises busy.
        op = MD_MTHI; a = 32'h1234_5678; start = 1'b1; d_uses_md = 1'b1;
        #1;
        chk("mthi_stall", {63'd0, md_stall}, 64'd0);
        step();
        start = 1'b0; d_uses_md = 1'b0;
        chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        chk("mthi_busy", {63'd0, busy}, 64'd0);

        op = MD_MTHI; a = 32'hDEAD_BEEF; start = 1'b1; exc_flush = 1'b1;
        step();
        start = 1'b0; exc_flush = 1'b0;
        chk("mthi_flush", {32'd0, hi}, {32'd0, 32'h1234_5678});

        // A flushed MULT must leave no trace.
        op = MD_MULT; a = 32'd9; b = 32'd9; start = 1'b1; exc_flush = 1'b1; d_uses_md = 1'b1;
        #1;
        chk("mult_flush_stall", {63'd0, md_stall}, 64'd1);
        step();
        start = 1'b0; exc_flush = 1'b0; d_uses_md = 1'b0;
        step();
        chk("mult_flush_busy", {63'd0, busy}, 64'd0);
        chk("mult_flush_hilo", {hi, lo}, {32'h1234_5678, 32'h8000_0000});

        run_op("mult_midflush", MD_MULT, 32'd7, 32'd6, 64'd42, 5, 2, 1'b1);

        // Reset in the third busy cycle of a DIV.
        op = MD_DIV; a = 32'd50; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("rst_mid_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        step();
        chk("rst_mid_quiet", {hi, lo, 31'd0, busy}, 96'd0);

        // Divide by zero keeps HI/LO but still takes the full latency.
        op = MD_MTLO; a = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'd5);
        run_op("div_zero", MD_DIV, 32'd77, 32'd0, {32'd0, 32'd5}, 10, -1, 1'b1);
        run_op("divu_zero", MD_DIVU, 32'd77, 32'd0, {32'd0, 32'd5}, 10, -1, 1'b0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
